multicycle_ctrl: RTL and testbench

- Multi-cycle control unit for the next processor generation; replaces the single-cycle combinational opcode decoder.
- Sequences each instruction through FETCH/DECODE/EXEC/MEM/WB states.
- Drives datapath enables and muxes one state at a time.
- Runs the multi-cycle multiply/divide handshake and the rstatus overflow/exception write-back.

---
 rtl/multicycle_ctrl_pkg.sv | 67 ++++++
 rtl/multicycle_ctrl_if.sv | 42 ++++
 rtl/multicycle_ctrl_op_decode.sv | 29 ++
 rtl/multicycle_ctrl.sv | 227 ++++++++++++++++++++++
 tb/tb_multicycle_ctrl.sv | 247 ++++++++++++++++++++++++
 5 files changed

// File: rtl/multicycle_ctrl_pkg.sv
// ctrl_pkg: shared types and encodings for the multi-cycle control unit.
//   state_t   - controller state encoding
//   iclass_t  - one-hot instruction class (all-zero means NOP)
//   OP_*      - opcode values (IR[31:27])
//   ALU_*     - ALU operation codes (IR[6:2])
//   EXC_*     - codes written to rstatus on an exception
//   PC_*, WD_*, WA_* - pc_sel, rf_wd_sel and rf_waddr_sel encodings
package ctrl_pkg;

  typedef enum logic [2:0] {
    ST_FETCH,
    ST_DECODE,
    ST_EXEC,
    ST_MDWAIT,
    ST_MEM,
    ST_WB
  } state_t;

  localparam logic [4:0] OP_RTYPE = 5'b00000;
  localparam logic [4:0] OP_J     = 5'b00001;
  localparam logic [4:0] OP_BNE   = 5'b00010;
  localparam logic [4:0] OP_JAL   = 5'b00011;
  localparam logic [4:0] OP_JR    = 5'b00100;
  localparam logic [4:0] OP_ADDI  = 5'b00101;
  localparam logic [4:0] OP_BLT   = 5'b00110;
  localparam logic [4:0] OP_SW    = 5'b00111;
  localparam logic [4:0] OP_LW    = 5'b01000;

  localparam logic [4:0] ALU_ADD = 5'b00000;
  localparam logic [4:0] ALU_SUB = 5'b00001;
  localparam logic [4:0] ALU_MUL = 5'b00110;
  localparam logic [4:0] ALU_DIV = 5'b00111;

  localparam logic [2:0] EXC_NONE = 3'd0;
  localparam logic [2:0] EXC_ADD  = 3'd1;
  localparam logic [2:0] EXC_ADDI = 3'd2;
  localparam logic [2:0] EXC_SUB  = 3'd3;
  localparam logic [2:0] EXC_MUL  = 3'd4;
  localparam logic [2:0] EXC_DIV  = 3'd5;

  localparam logic [1:0] PC_INC    = 2'd0;
  localparam logic [1:0] PC_BRANCH = 2'd1;
  localparam logic [1:0] PC_TARGET = 2'd2;
  localparam logic [1:0] PC_RD     = 2'd3;

  localparam logic [1:0] WD_RESULT = 2'd0;
  localparam logic [1:0] WD_DMEM   = 2'd1;
  localparam logic [1:0] WD_PC_INC = 2'd2;
  localparam logic [1:0] WD_EXC    = 2'd3;

  localparam logic [1:0] WA_RD      = 2'd0;
  localparam logic [1:0] WA_RSTATUS = 2'd1;
  localparam logic [1:0] WA_RA      = 2'd2;

  typedef struct packed {
    logic rtype;
    logic addi;
    logic sw;
    logic lw;
    logic j;
    logic jal;
    logic jr;
    logic bne;
    logic blt;
  } iclass_t;

endpackage

// File: rtl/multicycle_ctrl_if.sv
// multicycle_ctrl_if: bundle between the control unit and the datapath.
//   master modport - control unit: takes instruction fields and
//                    mult/div status, drives enables and mux selects
//   slave modport  - datapath side (mirror image)
// Signals: opcode, alu_op, alu_ovf, md_rdy, md_exc (to controller);
//   pc_we, ir_we, pc_sel, alu_inb_sel, alu_op_ctrl, md_start, dmem_we,
//   rf_we, rf_waddr_sel, rf_wd_sel, exc_code, busy (from controller).
interface multicycle_ctrl_if #(
  parameter int OP_W    = 5,
  parameter int ALUOP_W = 5
);
  logic [OP_W-1:0]    opcode;
  logic [ALUOP_W-1:0] alu_op;
  logic               alu_ovf;
  logic               md_rdy;
  logic               md_exc;

  logic               pc_we;
  logic               ir_we;
  logic [1:0]         pc_sel;
  logic               alu_inb_sel;
  logic [ALUOP_W-1:0] alu_op_ctrl;
  logic [1:0]         md_start;
  logic               dmem_we;
  logic               rf_we;
  logic [1:0]         rf_waddr_sel;
  logic [1:0]         rf_wd_sel;
  logic [2:0]         exc_code;
  logic               busy;

  modport master (
    input  opcode, alu_op, alu_ovf, md_rdy, md_exc,
    output pc_we, ir_we, pc_sel, alu_inb_sel, alu_op_ctrl, md_start,
           dmem_we, rf_we, rf_waddr_sel, rf_wd_sel, exc_code, busy
  );

  modport slave (
    output opcode, alu_op, alu_ovf, md_rdy, md_exc,
    input  pc_we, ir_we, pc_sel, alu_inb_sel, alu_op_ctrl, md_start,
           dmem_we, rf_we, rf_waddr_sel, rf_wd_sel, exc_code, busy
  );
endinterface

// File: rtl/multicycle_ctrl_op_decode.sv
// op_decode: combinational opcode to one-hot instruction class.
//   opcode - IR[31:27]
//   iclass - one-hot class; all-zero for any unlisted opcode (NOP)
module op_decode
  import ctrl_pkg::*;
#(
  parameter int OP_W = 5
) (
  input  logic [OP_W-1:0] opcode,
  output iclass_t         iclass
);

  always_comb begin
    iclass = '0;
    case (opcode)
      OP_W'(OP_RTYPE): iclass.rtype = 1'b1;
      OP_W'(OP_ADDI):  iclass.addi  = 1'b1;
      OP_W'(OP_SW):    iclass.sw    = 1'b1;
      OP_W'(OP_LW):    iclass.lw    = 1'b1;
      OP_W'(OP_J):     iclass.j     = 1'b1;
      OP_W'(OP_JAL):   iclass.jal   = 1'b1;
      OP_W'(OP_JR):    iclass.jr    = 1'b1;
      OP_W'(OP_BNE):   iclass.bne   = 1'b1;
      OP_W'(OP_BLT):   iclass.blt   = 1'b1;
      default:         iclass = '0;
    endcase
  end

endmodule

// File: rtl/multicycle_ctrl.sv
// multicycle_ctrl: multi-cycle control unit. Steps each instruction
// through FETCH/DECODE/EXEC/(MDWAIT|MEM)/WB and drives the datapath
// enables and mux selects for the current state only.
//   clock   - system clock, rising edge
//   reset_n - synchronous active-low reset
//   bus     - multicycle_ctrl_if.master (instruction fields, mult/div
//             handshake in; enables, selects, exc_code, busy out)
// Build option: define OVF_EXC_EN to enable ALU overflow and mult/div
// exceptions written to rstatus (r30). Without it, exceptions are never
// raised, though a mult/div timeout still forces write-back.
//
// state  | meaning
// FETCH  | load IR, PC <= PC+1
// DECODE | register instruction class; jumps finish here
// EXEC   | drive ALU; branches finish here; launch mult/div
// MDWAIT | wait for md_rdy or timeout
// MEM    | sw write, or lw read wait
// WB     | register file write (result, dmem, or rstatus)
module multicycle_ctrl
  import ctrl_pkg::*;
#(
  parameter int OP_W       = 5,
  parameter int ALUOP_W    = 5,
  parameter int MD_TIMEOUT = 40,
  parameter int MEM_WAIT   = 1
) (
  input  logic          clock,
  input  logic          reset_n,
  multicycle_ctrl_if.master bus
);

  // one counter serves both the mult/div timeout and the lw wait
  localparam int CNT_MAX = (MD_TIMEOUT > 7) ? MD_TIMEOUT : 7;
  localparam int CNT_W   = $clog2(CNT_MAX + 1);

  state_t             state, state_d;
  iclass_t            dec_class, iclass_q, iclass_d;
  logic [CNT_W-1:0]   cnt, cnt_d;
  logic               exc_pend, exc_pend_d;
  logic [2:0]         exc_code_q, exc_code_d;
  logic               md_div_q, md_div_d;
  logic               md_mul, md_div;

  logic               pc_we, ir_we, alu_inb_sel, dmem_we, rf_we;
  logic [1:0]         pc_sel, md_start, rf_waddr_sel, rf_wd_sel;
  logic [ALUOP_W-1:0] alu_op_ctrl;
  logic [2:0]         exc_code;

  op_decode #(.OP_W(OP_W)) u_op_decode (
    .opcode (bus.opcode),
    .iclass (dec_class)
  );

  assign md_mul = iclass_q.rtype && (bus.alu_op == ALUOP_W'(ALU_MUL));
  assign md_div = iclass_q.rtype && (bus.alu_op == ALUOP_W'(ALU_DIV));

  always_ff @(posedge clock) begin
    if (!reset_n) begin
      state      <= ST_FETCH;
      iclass_q   <= '0;
      cnt        <= '0;
      exc_pend   <= 1'b0;
      exc_code_q <= EXC_NONE;
      md_div_q   <= 1'b0;
    end else begin
      state      <= state_d;
      iclass_q   <= iclass_d;
      cnt        <= cnt_d;
      exc_pend   <= exc_pend_d;
      exc_code_q <= exc_code_d;
      md_div_q   <= md_div_d;
    end
  end

  always_comb begin
    state_d      = state;
    iclass_d     = iclass_q;
    cnt_d        = cnt;
    exc_pend_d   = exc_pend;
    exc_code_d   = exc_code_q;
    md_div_d     = md_div_q;
    pc_we        = 1'b0;
    ir_we        = 1'b0;
    pc_sel       = PC_INC;
    alu_inb_sel  = 1'b0;
    alu_op_ctrl  = '0;
    md_start     = 2'b00;
    dmem_we      = 1'b0;
    rf_we        = 1'b0;
    rf_waddr_sel = WA_RD;
    rf_wd_sel    = WD_RESULT;
    exc_code     = EXC_NONE;

    case (state)
      ST_FETCH: begin
        ir_we      = 1'b1;
        pc_we      = 1'b1;
        exc_pend_d = 1'b0;
        exc_code_d = EXC_NONE;
        state_d    = ST_DECODE;
      end

      ST_DECODE: begin
        iclass_d = dec_class;
        if (dec_class.j || dec_class.jal || dec_class.jr) begin
          pc_we   = 1'b1;
          pc_sel  = dec_class.jr ? PC_RD : PC_TARGET;
          if (dec_class.jal) begin
            rf_we        = 1'b1;
            rf_waddr_sel = WA_RA;
            rf_wd_sel    = WD_PC_INC;
          end
          state_d = ST_FETCH;
        end else if (dec_class.rtype || dec_class.addi || dec_class.sw ||
                     dec_class.lw || dec_class.bne || dec_class.blt) begin
          state_d = ST_EXEC;
        end else begin
          state_d = ST_FETCH;
        end
      end

      ST_EXEC: begin
        cnt_d = '0;
        if (iclass_q.rtype) alu_op_ctrl = bus.alu_op;
        if (iclass_q.addi || iclass_q.lw || iclass_q.sw) alu_inb_sel = 1'b1;
        if (iclass_q.bne || iclass_q.blt) begin
          // datapath qualifies pc_we with the ne/lt flag
          alu_op_ctrl = ALUOP_W'(ALU_SUB);
          pc_we       = 1'b1;
          pc_sel      = PC_BRANCH;
          state_d     = ST_FETCH;
        end else if (md_mul || md_div) begin
          md_start = {md_div, md_mul};
          md_div_d = md_div;
          state_d  = ST_MDWAIT;
        end else if (iclass_q.lw || iclass_q.sw) begin
          state_d = ST_MEM;
        end else begin
          state_d = ST_WB;
        end
`ifdef OVF_EXC_EN
        if (bus.alu_ovf) begin
          if (iclass_q.addi) begin
            exc_pend_d = 1'b1;
            exc_code_d = EXC_ADDI;
          end else if (iclass_q.rtype && bus.alu_op == ALUOP_W'(ALU_ADD)) begin
            exc_pend_d = 1'b1;
            exc_code_d = EXC_ADD;
          end else if (iclass_q.rtype && bus.alu_op == ALUOP_W'(ALU_SUB)) begin
            exc_pend_d = 1'b1;
            exc_code_d = EXC_SUB;
          end
        end
`endif
      end

      ST_MDWAIT: begin
        cnt_d = cnt + 1'b1;
        // md_rdy takes priority over a timeout landing in the same cycle
        if (bus.md_rdy) begin
          state_d = ST_WB;
`ifdef OVF_EXC_EN
          if (bus.md_exc) begin
            exc_pend_d = 1'b1;
            exc_code_d = md_div_q ? EXC_DIV : EXC_MUL;
          end
`endif
        end else if (cnt == CNT_W'(MD_TIMEOUT - 1)) begin
          state_d = ST_WB;
`ifdef OVF_EXC_EN
          exc_pend_d = 1'b1;
          exc_code_d = md_div_q ? EXC_DIV : EXC_MUL;
`endif
        end
      end

      ST_MEM: begin
        if (iclass_q.sw) begin
          dmem_we = 1'b1;
          state_d = ST_FETCH;
        end else if (cnt == CNT_W'(MEM_WAIT)) begin
          state_d = ST_WB;
        end else begin
          cnt_d = cnt + 1'b1;
        end
      end

      ST_WB: begin
        rf_we = 1'b1;
        if (iclass_q.lw) rf_wd_sel = WD_DMEM;
        if (exc_pend) begin
          rf_waddr_sel = WA_RSTATUS;
          rf_wd_sel    = WD_EXC;
          exc_code     = exc_code_q;
        end
        state_d = ST_FETCH;
      end

      default: state_d = ST_FETCH;
    endcase
  end

  // Jump classes are consumed straight from the decoder in DECODE.
  logic unused_cls;
  assign unused_cls = iclass_q.j ^ iclass_q.jal ^ iclass_q.jr;

`ifndef OVF_EXC_EN
  logic unused_exc;
  assign unused_exc = bus.alu_ovf ^ bus.md_exc ^ md_div_q;
`endif

  // While reset_n is held low every output reads idle, even though the
  // state register already sits in FETCH.
  assign bus.pc_we        = reset_n & pc_we;
  assign bus.ir_we        = reset_n & ir_we;
  assign bus.pc_sel       = reset_n ? pc_sel : 2'b00;
  assign bus.alu_inb_sel  = reset_n & alu_inb_sel;
  assign bus.alu_op_ctrl  = reset_n ? alu_op_ctrl : '0;
  assign bus.md_start     = reset_n ? md_start : 2'b00;
  assign bus.dmem_we      = reset_n & dmem_we;
  assign bus.rf_we        = reset_n & rf_we;
  assign bus.rf_waddr_sel = reset_n ? rf_waddr_sel : 2'b00;
  assign bus.rf_wd_sel    = reset_n ? rf_wd_sel : 2'b00;
  assign bus.exc_code     = reset_n ? exc_code : 3'b000;
  assign bus.busy         = reset_n & (state != ST_FETCH);

endmodule

// File: tb/tb_multicycle_ctrl.sv
// tb_multicycle_ctrl: directed scoreboard bench for multicycle_ctrl.
// The driver pushes one expected output vector per cycle of each
// instruction, then drives it; the monitor pops and compares on every
// falling edge while the queue holds entries.
module tb_multicycle_ctrl;
  import ctrl_pkg::*;

  logic clock;
  logic reset_n;

  multicycle_ctrl_if #(.OP_W(5), .ALUOP_W(5)) bus ();

  multicycle_ctrl #(
    .OP_W(5), .ALUOP_W(5), .MD_TIMEOUT(40), .MEM_WAIT(1)
  ) dut (
    .clock   (clock),
    .reset_n (reset_n),
    .bus     (bus)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  // {pc_we, ir_we, pc_sel, alu_inb_sel, alu_op_ctrl, md_start, dmem_we,
  //  rf_we, rf_waddr_sel, rf_wd_sel, exc_code, busy}
  logic [21:0] act;
  assign act = {bus.pc_we, bus.ir_we, bus.pc_sel, bus.alu_inb_sel,
                bus.alu_op_ctrl, bus.md_start, bus.dmem_we, bus.rf_we,
                bus.rf_waddr_sel, bus.rf_wd_sel, bus.exc_code, bus.busy};

  logic [21:0] exp_q[$];
  string       name_q[$];
  int          n_issue;
  int          n_cmp;
  int          n_err;
  logic        done;
  logic        end_chk;

  function automatic logic [21:0] mk(
    input logic pcwe, input logic irwe, input logic [1:0] pcsel,
    input logic inb, input logic [4:0] aop, input logic [1:0] mds,
    input logic dwe, input logic rfwe, input logic [1:0] wa,
    input logic [1:0] wd, input logic [2:0] ec, input logic bsy);
    return {pcwe, irwe, pcsel, inb, aop, mds, dwe, rfwe, wa, wd, ec, bsy};
  endfunction

  logic [21:0] V_FETCH, V_IDLE, V_WB, V_ZERO, V_INB;

  function automatic logic [21:0] wb_exc(input logic [2:0] code);
`ifdef OVF_EXC_EN
    return mk(0, 0, 2'd0, 0, 5'd0, 2'd0, 0, 1, 2'd1, 2'd3, code, 1);
`else
    return mk(0, 0, 2'd0, 0, 5'd0, 2'd0, 0, 1, 2'd0, 2'd0, 3'd0 & code, 1);
`endif
  endfunction

  task automatic expect_v(input string nm, input logic [21:0] v);
    exp_q.push_back(v);
    name_q.push_back(nm);
    n_issue++;
  endtask

  task automatic expect_idle(input string nm, input int n);
    for (int k = 0; k < n; k++) expect_v(nm, V_IDLE);
  endtask

  // Runs as many cycles as entries were pushed; rdy_at is the cycle
  // index (FETCH = 0) carrying the md_rdy pulse, -1 for none.
  task automatic go(input logic [4:0] op, input logic [4:0] aop,
                    input logic ovf, input int rdy_at, input logic mexc);
    int n;
    n = n_issue;
    n_issue = 0;
    bus.opcode  = op;
    bus.alu_op  = aop;
    bus.alu_ovf = ovf;
    for (int i = 0; i < n; i++) begin
      bus.md_rdy = (i == rdy_at);
      bus.md_exc = (i == rdy_at) ? mexc : 1'b0;
      @(posedge clock);
      #1;
    end
    bus.md_rdy  = 1'b0;
    bus.md_exc  = 1'b0;
    bus.alu_ovf = 1'b0;
  endtask

  always @(negedge clock) begin
    logic [21:0] ev;
    string nm;
    if (exp_q.size() > 0) begin
      ev = exp_q.pop_front();
      nm = name_q.pop_front();
      n_cmp++;
      if (act !== ev) begin
        n_err++;
        $display("FAIL %s: got %06h expected %06h at %0t", nm, act, ev, $time);
      end
    end else if (done && !end_chk) begin
      end_chk = 1'b1;
      n_cmp++;
      if (exp_q.size() != 0) begin
        n_err++;
        $display("FAIL drain: got %0d entries left expected 0", exp_q.size());
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: got no finish expected finish by 100000");
    $fatal(1, "watchdog");
  end

  initial begin
    n_issue = 0; n_cmp = 0; n_err = 0; done = 1'b0; end_chk = 1'b0;
    V_FETCH = mk(1, 1, 2'd0, 0, 5'd0, 2'd0, 0, 0, 2'd0, 2'd0, 3'd0, 0);
    V_IDLE  = mk(0, 0, 2'd0, 0, 5'd0, 2'd0, 0, 0, 2'd0, 2'd0, 3'd0, 1);
    V_WB    = mk(0, 0, 2'd0, 0, 5'd0, 2'd0, 0, 1, 2'd0, 2'd0, 3'd0, 1);
    V_INB   = mk(0, 0, 2'd0, 1, 5'd0, 2'd0, 0, 0, 2'd0, 2'd0, 3'd0, 1);
    V_ZERO  = '0;
    reset_n = 1'b0;
    bus.opcode = '0; bus.alu_op = '0; bus.alu_ovf = 1'b0;
    bus.md_rdy = 1'b0; bus.md_exc = 1'b0;

    @(posedge clock); #1;
    expect_v("reset_hold", V_ZERO);
    go(5'b11111, ALU_ADD, 0, -1, 0);
    reset_n = 1'b1;

    // R-type add: 4 cycles
    expect_v("add_fetch", V_FETCH); expect_v("add_dec", V_IDLE);
    expect_v("add_exec", V_IDLE);   expect_v("add_wb", V_WB);
    go(OP_RTYPE, ALU_ADD, 0, -1, 0);

    // R-type with another alu_op: passed straight to alu_op_ctrl
    expect_v("and_fetch", V_FETCH); expect_v("and_dec", V_IDLE);
    expect_v("and_exec", mk(0, 0, 2'd0, 0, 5'd3, 2'd0, 0, 0, 2'd0, 2'd0, 3'd0, 1));
    expect_v("and_wb", V_WB);
    go(OP_RTYPE, 5'd3, 0, -1, 0);

    expect_v("addi_fetch", V_FETCH); expect_v("addi_dec", V_IDLE);
    expect_v("addi_exec", V_INB);    expect_v("addi_wb", V_WB);
    go(OP_ADDI, 5'd9, 0, -1, 0);

    // lw, MEM_WAIT=1: write-back on cycle 5
    expect_v("lw_fetch", V_FETCH); expect_v("lw_dec", V_IDLE);
    expect_v("lw_exec", V_INB);    expect_v("lw_mem0", V_IDLE);
    expect_v("lw_mem1", V_IDLE);
    expect_v("lw_wb", mk(0, 0, 2'd0, 0, 5'd0, 2'd0, 0, 1, 2'd0, 2'd1, 3'd0, 1));
    go(OP_LW, 5'd0, 0, -1, 0);

    expect_v("sw_fetch", V_FETCH); expect_v("sw_dec", V_IDLE);
    expect_v("sw_exec", V_INB);
    expect_v("sw_mem", mk(0, 0, 2'd0, 0, 5'd0, 2'd0, 1, 0, 2'd0, 2'd0, 3'd0, 1));
    go(OP_SW, 5'd0, 0, -1, 0);

    expect_v("j_fetch", V_FETCH);
    expect_v("j_dec", mk(1, 0, 2'd2, 0, 5'd0, 2'd0, 0, 0, 2'd0, 2'd0, 3'd0, 1));
    go(OP_J, 5'd0, 0, -1, 0);

    expect_v("jal_fetch", V_FETCH);
    expect_v("jal_dec", mk(1, 0, 2'd2, 0, 5'd0, 2'd0, 0, 1, 2'd2, 2'd2, 3'd0, 1));
    go(OP_JAL, 5'd0, 0, -1, 0);

    expect_v("nop_fetch", V_FETCH); expect_v("nop_dec", V_IDLE);
    go(5'b11111, 5'd0, 0, -1, 0);

    expect_v("jr_fetch", V_FETCH);
    expect_v("jr_dec", mk(1, 0, 2'd3, 0, 5'd0, 2'd0, 0, 0, 2'd0, 2'd0, 3'd0, 1));
    go(OP_JR, 5'd0, 0, -1, 0);

    expect_v("bne_fetch", V_FETCH); expect_v("bne_dec", V_IDLE);
    expect_v("bne_exec", mk(1, 0, 2'd1, 0, 5'd1, 2'd0, 0, 0, 2'd0, 2'd0, 3'd0, 1));
    go(OP_BNE, 5'd0, 0, -1, 0);

    expect_v("blt_fetch", V_FETCH); expect_v("blt_dec", V_IDLE);
    expect_v("blt_exec", mk(1, 0, 2'd1, 0, 5'd1, 2'd0, 0, 0, 2'd0, 2'd0, 3'd0, 1));
    go(OP_BLT, 5'd0, 0, -1, 0);

    // mul, md_rdy with md_exc on MDWAIT cycle 17 (cycle index 19)
    expect_v("mul_fetch", V_FETCH); expect_v("mul_dec", V_IDLE);
    expect_v("mul_exec", mk(0, 0, 2'd0, 0, 5'd6, 2'b01, 0, 0, 2'd0, 2'd0, 3'd0, 1));
    expect_idle("mul_wait", 17);
    expect_v("mul_wb", wb_exc(3'd4));
    go(OP_RTYPE, ALU_MUL, 0, 19, 1);

    // exception state must not leak into the next instruction
    expect_v("add2_fetch", V_FETCH); expect_v("add2_dec", V_IDLE);
    expect_v("add2_exec", V_IDLE);   expect_v("add2_wb", V_WB);
    go(OP_RTYPE, ALU_ADD, 0, -1, 0);

    // div with no md_rdy: 40 MDWAIT cycles then forced WB
    expect_v("divto_fetch", V_FETCH); expect_v("divto_dec", V_IDLE);
    expect_v("divto_exec", mk(0, 0, 2'd0, 0, 5'd7, 2'b10, 0, 0, 2'd0, 2'd0, 3'd0, 1));
    expect_idle("divto_wait", 40);
    expect_v("divto_wb", wb_exc(3'd5));
    go(OP_RTYPE, ALU_DIV, 0, -1, 0);

    // md_rdy on the timeout cycle, md_exc=0: md_rdy wins, no exception
    expect_v("divtie_fetch", V_FETCH); expect_v("divtie_dec", V_IDLE);
    expect_v("divtie_exec", mk(0, 0, 2'd0, 0, 5'd7, 2'b10, 0, 0, 2'd0, 2'd0, 3'd0, 1));
    expect_idle("divtie_wait", 40);
    expect_v("divtie_wb", V_WB);
    go(OP_RTYPE, ALU_DIV, 0, 42, 0);

    // mul with md_rdy on the first MDWAIT cycle
    expect_v("mul1_fetch", V_FETCH); expect_v("mul1_dec", V_IDLE);
    expect_v("mul1_exec", mk(0, 0, 2'd0, 0, 5'd6, 2'b01, 0, 0, 2'd0, 2'd0, 3'd0, 1));
    expect_idle("mul1_wait", 1);
    expect_v("mul1_wb", V_WB);
    go(OP_RTYPE, ALU_MUL, 0, 3, 0);

    // ALU overflow in EXEC
    expect_v("addovf_fetch", V_FETCH); expect_v("addovf_dec", V_IDLE);
    expect_v("addovf_exec", V_IDLE);   expect_v("addovf_wb", wb_exc(3'd1));
    go(OP_RTYPE, ALU_ADD, 1, -1, 0);

    expect_v("addiovf_fetch", V_FETCH); expect_v("addiovf_dec", V_IDLE);
    expect_v("addiovf_exec", V_INB);    expect_v("addiovf_wb", wb_exc(3'd2));
    go(OP_ADDI, 5'd0, 1, -1, 0);

    expect_v("subovf_fetch", V_FETCH); expect_v("subovf_dec", V_IDLE);
    expect_v("subovf_exec", mk(0, 0, 2'd0, 0, 5'd1, 2'd0, 0, 0, 2'd0, 2'd0, 3'd0, 1));
    expect_v("subovf_wb", wb_exc(3'd3));
    go(OP_RTYPE, ALU_SUB, 1, -1, 0);

    // reset in the 8th MDWAIT cycle (counter = 7), low for one edge
    expect_v("rmd_fetch", V_FETCH); expect_v("rmd_dec", V_IDLE);
    expect_v("rmd_exec", mk(0, 0, 2'd0, 0, 5'd6, 2'b01, 0, 0, 2'd0, 2'd0, 3'd0, 1));
    expect_idle("rmd_wait", 7);
    go(OP_RTYPE, ALU_MUL, 0, -1, 0);
    reset_n = 1'b0;
    expect_v("rmd_reset", V_ZERO);
    go(OP_RTYPE, ALU_MUL, 0, -1, 0);
    reset_n = 1'b1;
    expect_v("rmd_post_fetch", V_FETCH); expect_v("rmd_post_dec", V_IDLE);
    expect_v("rmd_post_exec", V_IDLE);   expect_v("rmd_post_wb", V_WB);
    go(OP_RTYPE, ALU_ADD, 0, -1, 0);

    done = 1'b1;
    repeat (3) @(posedge clock);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
